// File: rtl/jtag_tap_gen2_if.sv
// Serial JTAG pins of the TAP: the tester (master) drives tms/tdi, the TAP (slave) returns tdo/tdo_oe.
// tdo/tdo_oe change only on the falling edge of tck, so the tester samples them just before the next rising edge.
interface jtag_tap_gen2_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  modport master (output tms, output tdi, input tdo, input tdo_oe);
  modport slave  (input tms, input tdi, output tdo, output tdo_oe);
endinterface

// File: rtl/jtag_tap_gen2.sv
// IEEE 1149.1 TAP controller with IR, BYPASS, IDCODE, boundary-scan and a user data register.
// Capture and shift happen on rising tck; update registers and tdo change on falling tck.
module jtag_tap_gen2 #(
  parameter int unsigned IR_LEN   = 5,
  parameter int unsigned N_IN     = 4,
  parameter int unsigned N_OUT    = 4,
  parameter int unsigned USER_LEN = 8,
  parameter logic [31:0] IDCODE   = 32'h1001_C0DF
) (
  input  logic                tck,
  input  logic                trst_n,
  jtag_tap_gen2_if.slave      jtag,
  input  logic [N_IN-1:0]     pin_in,
  output logic [N_IN-1:0]     core_in,
  input  logic [N_OUT-1:0]    core_out,
  output logic [N_OUT-1:0]    pin_out,
  input  logic [USER_LEN-1:0] user_rdata,
  output logic [USER_LEN-1:0] user_wdata,
  output logic                user_wvalid,
  output logic [3:0]          tap_state
);
  localparam int unsigned BSR_LEN = N_IN + N_OUT;
  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(1);

  typedef enum logic [3:0] {
    TLR = 4'd0, RTI = 4'd1, SEL_DR = 4'd2, CAP_DR = 4'd3, SH_DR = 4'd4, EX1_DR = 4'd5,
    PAU_DR = 4'd6, EX2_DR = 4'd7, UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10,
    SH_IR = 4'd11, EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } state_e;

  state_e state_q, state_d;
  logic in_tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;
  logic sel_bypass, sel_idcode, sel_bsr, sel_user, is_extest, is_intest;
  logic [IR_LEN-1:0]   ir_sr_q, ir_q;
  logic                bypass_q;
  logic [31:0]         idcode_sr_q;
  logic [BSR_LEN-1:0]  bsr_sr_q, bsr_upd_q;
  logic [USER_LEN-1:0] user_sr_q, user_wdata_q;
  logic                user_wvalid_q, tdo_q, tdo_oe_q, tdo_bit;
  logic [USER_LEN:0]   user_shift;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state_q <= TLR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = jtag.tms ? TLR    : RTI;
      RTI:    state_d = jtag.tms ? SEL_DR : RTI;
      SEL_DR: state_d = jtag.tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = jtag.tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = jtag.tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = jtag.tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = jtag.tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = jtag.tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = jtag.tms ? SEL_DR : RTI;
      SEL_IR: state_d = jtag.tms ? TLR    : CAP_IR;
      CAP_IR: state_d = jtag.tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = jtag.tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = jtag.tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = jtag.tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = jtag.tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = jtag.tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_comb begin
    in_tlr = (state_q == TLR);
    cap_dr = (state_q == CAP_DR);
    sh_dr  = (state_q == SH_DR);
    upd_dr = (state_q == UPD_DR);
    cap_ir = (state_q == CAP_IR);
    sh_ir  = (state_q == SH_IR);
    upd_ir = (state_q == UPD_IR);
  end

  // Unassigned instruction codes fall back to BYPASS; all-ones wins even when it aliases a code.
  always_comb begin
    sel_bypass = 1'b0;
    sel_idcode = 1'b0;
    sel_bsr    = 1'b0;
    sel_user   = 1'b0;
    is_extest  = 1'b0;
    is_intest  = 1'b0;
    if (&ir_q)                    sel_bypass = 1'b1;
    else if (ir_q == IR_LEN'(0)) begin sel_bsr = 1'b1; is_extest = 1'b1; end
    else if (ir_q == IR_LEN'(1))  sel_idcode = 1'b1;
    else if (ir_q == IR_LEN'(2))  sel_bsr    = 1'b1;
    else if (ir_q == IR_LEN'(3)) begin sel_bsr = 1'b1; is_intest = 1'b1; end
    else if (ir_q == IR_LEN'(4))  sel_user   = 1'b1;
    else                          sel_bypass = 1'b1;
  end

  assign user_shift = {jtag.tdi, user_sr_q};

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_sr_q     <= '0;
      bypass_q    <= 1'b0;
      idcode_sr_q <= '0;
      bsr_sr_q    <= '0;
      user_sr_q   <= '0;
    end else begin
      if (cap_ir)     ir_sr_q <= IR_LEN'(1);
      else if (sh_ir) ir_sr_q <= {jtag.tdi, ir_sr_q[IR_LEN-1:1]};
      if (sel_bypass) begin
        if (cap_dr)     bypass_q <= 1'b0;
        else if (sh_dr) bypass_q <= jtag.tdi;
      end
      if (sel_idcode) begin
        if (cap_dr)     idcode_sr_q <= IDCODE | 32'd1;
        else if (sh_dr) idcode_sr_q <= {jtag.tdi, idcode_sr_q[31:1]};
      end
      if (sel_bsr) begin
        if (cap_dr)     bsr_sr_q <= {core_out, pin_in};
        else if (sh_dr) bsr_sr_q <= {jtag.tdi, bsr_sr_q[BSR_LEN-1:1]};
      end
      if (sel_user) begin
        if (cap_dr)     user_sr_q <= user_rdata;
        else if (sh_dr) user_sr_q <= user_shift[USER_LEN:1];
      end
    end
  end

  always_comb begin
    tdo_bit = user_sr_q[0];
    if (sh_ir)           tdo_bit = ir_sr_q[0];
    else if (sel_bypass) tdo_bit = bypass_q;
    else if (sel_idcode) tdo_bit = idcode_sr_q[0];
    else if (sel_bsr)    tdo_bit = bsr_sr_q[0];
  end

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_q          <= IR_IDCODE;
      bsr_upd_q     <= '0;
      user_wdata_q  <= '0;
      user_wvalid_q <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
    end else begin
      if (in_tlr)      ir_q <= IR_IDCODE;
      else if (upd_ir) ir_q <= ir_sr_q;
      if (upd_dr && sel_bsr) bsr_upd_q <= bsr_sr_q;
      user_wvalid_q <= upd_dr && sel_user;
      if (upd_dr && sel_user) user_wdata_q <= user_sr_q;
      tdo_oe_q <= sh_ir || sh_dr;
      if (sh_ir || sh_dr) tdo_q <= tdo_bit;
    end
  end

  assign jtag.tdo    = tdo_q;
  assign jtag.tdo_oe = tdo_oe_q;
  assign pin_out     = is_extest ? bsr_upd_q[BSR_LEN-1:N_IN] : core_out;
  assign core_in     = is_intest ? bsr_upd_q[N_IN-1:0] : pin_in;
  assign user_wdata  = user_wdata_q;
  assign user_wvalid = user_wvalid_q;
  assign tap_state   = state_q;
endmodule

// File: tb/tb_jtag_tap_gen2.sv
// Directed bench for jtag_tap_gen2: scan tasks predict each scan's tdo stream and shifted-in content,
// a table-driven TAP model tracks state, and one negedge process compares every DUT output each cycle.
module tb_jtag_tap_gen2;
  localparam int IR_LEN = 5, N_IN = 4, N_OUT = 4, USER_LEN = 8;
  localparam int BSR_LEN = N_IN + N_OUT;
  localparam logic [31:0] IDCODE = 32'h1001_C0DF;
  localparam int K_BYP = 0, K_EXT = 1, K_ID = 2, K_SMP = 3, K_INT = 4, K_USR = 5;
  localparam int S_TLR = 0, S_SH_DR = 4, S_UPD_DR = 8, S_SH_IR = 11, S_UPD_IR = 15;

  logic tck = 1'b0;
  logic trst_n = 1'b1;
  logic [N_IN-1:0] pin_in, core_in;
  logic [N_OUT-1:0] core_out, pin_out;
  logic [USER_LEN-1:0] user_rdata, user_wdata;
  logic user_wvalid;
  logic [3:0] tap_state;
  jtag_tap_gen2_if j();

  jtag_tap_gen2 #(.IR_LEN(IR_LEN), .N_IN(N_IN), .N_OUT(N_OUT), .USER_LEN(USER_LEN), .IDCODE(IDCODE)) dut (
    .tck(tck), .trst_n(trst_n), .jtag(j), .pin_in(pin_in), .core_in(core_in),
    .core_out(core_out), .pin_out(pin_out), .user_rdata(user_rdata), .user_wdata(user_wdata),
    .user_wvalid(user_wvalid), .tap_state(tap_state));

  always #5 tck = ~tck;

  // TAP transition table indexed [state][tms], straight from the 1149.1 state diagram
  int nxt [16][2] = '{'{1,0}, '{1,2}, '{3,9}, '{4,5}, '{4,5}, '{6,8}, '{6,7}, '{4,8},
                      '{1,2}, '{10,0}, '{11,12}, '{11,12}, '{13,15}, '{13,14}, '{11,15}, '{1,2}};
  int m_state = 0;
  logic [IR_LEN-1:0] m_ir = IR_LEN'(1), m_ir_next = IR_LEN'(1);
  logic [BSR_LEN-1:0] m_bsr_upd = '0, m_bsr_next = '0;
  logic [USER_LEN-1:0] m_wdata = '0, m_user_next = '0;
  logic m_wvalid = 1'b0, m_oe = 1'b0, m_tdo = 1'b0;
  logic exp_q[$];
  logic got_q[$];
  int n_tests = 0, n_fail = 0, wvalid_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int kind(input logic [IR_LEN-1:0] ir);
    if (&ir) return K_BYP;
    case (int'(ir))
      0: return K_EXT;
      1: return K_ID;
      2: return K_SMP;
      3: return K_INT;
      4: return K_USR;
      default: return K_BYP;
    endcase
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) m_state = S_TLR;
    else         m_state = nxt[m_state][j.tms];
  end

  // compare process: apply falling-edge effects to the model, then check all outputs
  always begin
    @(negedge tck);
    if (!trst_n) begin
      m_ir = IR_LEN'(1); m_bsr_upd = '0; m_wdata = '0; m_wvalid = 1'b0;
      m_oe = 1'b0; m_tdo = 1'b0; exp_q.delete();
    end else begin
      if (m_state == S_TLR) m_ir = IR_LEN'(1);
      if (m_state == S_UPD_IR) m_ir = m_ir_next;
      if (m_state == S_UPD_DR && kind(m_ir) inside {K_EXT, K_SMP, K_INT}) m_bsr_upd = m_bsr_next;
      m_wvalid = (m_state == S_UPD_DR) && (kind(m_ir) == K_USR);
      if (m_wvalid) m_wdata = m_user_next;
      m_oe = (m_state == S_SH_DR) || (m_state == S_SH_IR);
      if (m_oe) begin
        if (exp_q.size() == 0) chk("exp_underflow", 64'd1, 64'd0);
        else m_tdo = exp_q.pop_front();
      end
    end
    #1;
    chk("tap_state", tap_state, m_state);
    chk("tdo_oe", j.tdo_oe, m_oe);
    chk("tdo", j.tdo, m_tdo);
    chk("pin_out", pin_out, (kind(m_ir) == K_EXT) ? m_bsr_upd[BSR_LEN-1:N_IN] : core_out);
    chk("core_in", core_in, (kind(m_ir) == K_INT) ? m_bsr_upd[N_IN-1:0] : pin_in);
    chk("user_wdata", user_wdata, m_wdata);
    chk("user_wvalid", user_wvalid, m_wvalid);
    if (m_oe) got_q.push_back(j.tdo);
    if (user_wvalid) wvalid_cnt++;
  end

  task automatic step(input logic tms, input logic tdi);
    @(negedge tck);
    #2;
    j.tms = tms;
    j.tdi = tdi;
    @(posedge tck);
  endtask

  // Starts and ends in RTI; optional pause after pause_at bits. Out stream = captured value then tdi bits.
  task automatic scan(input bit is_ir, input logic [63:0] data, input int nbits,
                      input int pause_at, output logic [63:0] got);
    logic [127:0] comb;
    logic [63:0] cap, content;
    int len, k;
    k = kind(m_ir);
    if (is_ir) begin len = IR_LEN; cap = 64'd1; end
    else case (k)
      K_BYP:   begin len = 1;        cap = 64'd0; end
      K_ID:    begin len = 32;       cap = {32'd0, IDCODE | 32'd1}; end
      K_USR:   begin len = USER_LEN; cap = {56'd0, user_rdata}; end
      default: begin len = BSR_LEN;  cap = {56'd0, core_out, pin_in}; end
    endcase
    comb = ({64'd0, data} << len) | {64'd0, cap};
    content = 64'(comb >> nbits) & ((64'd1 << len) - 64'd1);
    if (is_ir) m_ir_next = content[IR_LEN-1:0];
    else if (k == K_USR) m_user_next = content[USER_LEN-1:0];
    else if (k != K_BYP && k != K_ID) m_bsr_next = content[BSR_LEN-1:0];
    got_q.delete();
    for (int i = 0; i < nbits; i++) exp_q.push_back(comb[i]);
    step(1, 0);
    if (is_ir) step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < nbits; i++) begin
      step((i == nbits - 1) || (i == pause_at - 1), data[i]);
      if (i == pause_at - 1 && i != nbits - 1) begin
        step(0, 0); step(0, 0); step(1, 0); step(0, 0);
      end
    end
    step(1, 0);
    step(0, 0);
    got = '0;
    foreach (got_q[i]) got[i] = got_q[i];
  endtask

  logic [63:0] got;

  initial begin
    j.tms = 1'b1; j.tdi = 1'b0;
    pin_in = 4'h9; core_out = 4'h6; user_rdata = 8'h3C;
    #1 trst_n = 1'b0;
    #12;
    chk("reset_tap_state", tap_state, 0);
    chk("reset_tdo_oe", j.tdo_oe, 0);
    chk("reset_wvalid", user_wvalid, 0);
    #9 trst_n = 1'b1;
    step(0, 0);

    scan(0, 64'd0, 32, 0, got);
    chk("idcode_scan", got, 64'h1001_C0DF);

    scan(1, 64'h1F, 5, 0, got);
    chk("ir_capture_first2", got[1:0], 2'b01);
    chk("ir_capture_full", got, 64'h01);
    scan(0, 64'hA5, 9, 0, got);
    chk("bypass_a5_plus1", got, 64'h14A);

    scan(1, 64'h0A, 5, 0, got);
    scan(0, 64'hB, 4, 0, got);
    chk("unknown_is_bypass", got, 64'h6);

    scan(1, 64'h00, 5, 0, got);
    scan(0, 64'hC3, 8, 0, got);
    chk("extest_capture", got, 64'h69);
    #1 chk("extest_pin_out", pin_out, 4'hC);

    scan(1, 64'h02, 5, 0, got);
    #1 chk("sample_pin_out", pin_out, 4'h6);
    scan(0, 64'h00, 8, 3, got);
    chk("sample_capture", got, 64'h69);

    scan(1, 64'h03, 5, 0, got);
    scan(0, 64'h5E, 8, 0, got);
    #1 chk("intest_core_in", core_in, 4'hE);

    scan(1, 64'h04, 5, 2, got);
    wvalid_cnt = 0;
    scan(0, 64'h5A, 8, 0, got);
    chk("user_capture", got, 64'h3C);
    chk("user_wdata", user_wdata, 8'h5A);
    chk("user_wvalid_pulses", wvalid_cnt, 1);

    // reset in the middle of a USER shift
    wvalid_cnt = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(user_rdata[i]);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 3; i++) step(0, 1);
    #2 trst_n = 1'b0;
    step(1, 0); step(1, 0);
    #1 chk("midshift_tap_state", tap_state, 0);
    chk("midshift_wdata", user_wdata, 0);
    @(negedge tck); #2 trst_n = 1'b1;
    step(1, 0); step(1, 0);
    chk("midshift_no_wvalid", wvalid_cnt, 0);
    step(0, 0);
    scan(0, 64'd0, 32, 0, got);
    chk("ir_idcode_after_reset", got, 64'h1001_C0DF);

    // TLR reached through TMS restores IDCODE
    scan(1, 64'h04, 5, 0, got);
    for (int i = 0; i < 5; i++) step(1, 0);
    step(0, 0);
    scan(0, 64'd0, 32, 0, got);
    chk("ir_idcode_after_tlr", got, 64'h1001_C0DF);

    // five TMS=1 from UPD_IR
    m_ir_next = IR_LEN'(1);
    step(1, 0); step(1, 0); step(0, 0); step(1, 0); step(1, 0);
    #1 chk("at_upd_ir", tap_state, 15);
    for (int i = 0; i < 5; i++) step(1, 0);
    #1 chk("five_tms_to_tlr", tap_state, 0);
    step(0, 0); step(0, 0);
    @(negedge tck); #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
